// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD-card target model (mode 0, MSB first).
// Frames 6-byte commands from the host and reports them to local logic.
// It returns an R1 byte after NCR_BYTES fill bytes of 0xFF.
// Ports:
//   clock_i, reset_i          system clock, async active-high reset
//   spi_sclk_i/mosi_i/cs_i    host SPI inputs (cs active low)
//   spi_miso_o                card-to-host data
//   rx_data_o, rx_valid_o     last received byte and a 1-clock strobe
//   cmd_valid_o               1-clock strobe per captured command frame
//   cmd_index_o/arg_o/crc_o   command fields, held until the next frame
//   crc_err_o                 CRC7 mismatch, qualified by cmd_valid_o
//   resp_r1_i                 R1 value, sampled while cmd_valid_o=1
// Optional feature: define SD_RESP_CRC_CHECK_EN to enable CRC7 checking.
// When enabled, a bad CRC sets crc_err_o and ORs 0x08 into the R1 byte.
module sd_spi_responder #(
    parameter int NCR_BYTES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        spi_sclk_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_i,
    output logic        spi_miso_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [6:0]  cmd_crc_o,
    output logic        crc_err_o,
    input  logic [7:0]  resp_r1_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_CMD,
        S_NCR,
        S_RESP
    } state_e;

    localparam logic [3:0] NCR_LAST = 4'(NCR_BYTES - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    // The cs chain resets low: a card held selected through reset sees
    // no falling edge, so the host must toggle cs before framing resumes.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [37:0] frame_q, frame_d;
    logic [3:0]  ncr_cnt_q, ncr_cnt_d;
    logic [7:0]  r1_q, r1_d;

    logic [7:0]  rx_byte;
    logic [7:0]  tx_load;
    logic [7:0]  r1_sel;
    logic        active;
    logic        byte_done;

    // Byte 0 always starts with 2'b01, so only its index bits are stored.
    assign rx_byte   = {rx_sh_q, mosi_s};
    assign tx_load   = (state_q == S_RESP) ? r1_q : 8'hFF;
    assign active    = ~cs_s & (state_q != S_IDLE);
    assign byte_done = active & sclk_rise & (bit_cnt_q == 3'd7);

`ifdef SD_RESP_CRC_CHECK_EN
    logic crc_err_q, crc_err_d;
    logic crc_bad;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc_bad = crc7({2'b01, frame_q}) != rx_byte[7:1];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) crc_err_q <= 1'b0;
        else         crc_err_q <= crc_err_d;
    end

    assign crc_err_o = crc_err_q;
    assign r1_sel    = resp_r1_i | {4'b0, crc_err_q, 3'b0};
`else
    assign crc_err_o = 1'b0;
    assign r1_sel    = resp_r1_i;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= 8'hFF;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
            crc_q       <= '0;
            byte_cnt_q  <= '0;
            frame_q     <= '0;
            ncr_cnt_q   <= '0;
            r1_q        <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            cmd_valid_q <= cmd_valid_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            crc_q       <= crc_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_q     <= frame_d;
            ncr_cnt_q   <= ncr_cnt_d;
            r1_q        <= r1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        cmd_valid_d = 1'b0;
        index_d     = index_q;
        arg_d       = arg_q;
        crc_d       = crc_q;
        byte_cnt_d  = byte_cnt_q;
        frame_d     = frame_q;
        ncr_cnt_d   = ncr_cnt_q;
        r1_d        = r1_q;
`ifdef SD_RESP_CRC_CHECK_EN
        crc_err_d   = crc_err_q;
`endif

        if (cmd_valid_q) r1_d = r1_sel;

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            tx_sh_d   = 8'hFF;
        end else if (cs_fall) begin
            state_d   = S_HUNT;
            bit_cnt_d = '0;
            tx_sh_d   = 8'hFF;
        end else if (active) begin
            if (sclk_rise) begin
                rx_sh_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // bit_cnt is 0 on a falling edge only after a whole byte.
            if (sclk_fall) begin
                if (bit_cnt_q == 3'd0) tx_sh_d = tx_load;
                else                   tx_sh_d = {tx_sh_q[6:0], 1'b1};
            end
            if (byte_done) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
                unique case (state_q)
                    S_IDLE: ;
                    S_HUNT: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            state_d    = S_CMD;
                            byte_cnt_d = 3'd1;
                            frame_d    = {32'h0, rx_byte[5:0]};
                        end
                    end
                    S_CMD: begin
                        if (byte_cnt_q == 3'd5) begin
                            cmd_valid_d = 1'b1;
                            index_d     = frame_q[37:32];
                            arg_d       = frame_q[31:0];
                            crc_d       = rx_byte[7:1];
`ifdef SD_RESP_CRC_CHECK_EN
                            crc_err_d   = crc_bad;
`endif
                            ncr_cnt_d   = '0;
                            state_d     = S_NCR;
                        end else begin
                            frame_d    = {frame_q[29:0], rx_byte};
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                    S_NCR: begin
                        if (ncr_cnt_q == NCR_LAST) state_d = S_RESP;
                        else ncr_cnt_d = ncr_cnt_q + 4'd1;
                    end
                    S_RESP: state_d = S_HUNT;
                endcase
            end
        end
    end

    assign spi_miso_o  = tx_sh_q[7];
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_index_o = index_q;
    assign cmd_arg_o   = arg_q;
    assign cmd_crc_o   = crc_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Testbench for sd_spi_responder: an SPI host drives framed sessions.
// A byte-level model predicts the MISO stream, the rx bytes and the command fields.
module tb_sd_spi_responder;

    localparam int NCR = 2;
`ifdef SD_RESP_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b1;
    logic        cs = 1'b1;
    logic [7:0]  resp_r1 = 8'h00;
    logic        miso;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        crc_err;

    always #5 clk = ~clk;

    sd_spi_responder #(.NCR_BYTES(NCR), .SYNC_STAGES(2)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .spi_sclk_i  (sclk),
        .spi_mosi_i  (mosi),
        .spi_cs_i    (cs),
        .spi_miso_o  (miso),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .cmd_valid_o (cmd_valid),
        .cmd_index_o (cmd_index),
        .cmd_arg_o   (cmd_arg),
        .cmd_crc_o   (cmd_crc),
        .crc_err_o   (crc_err),
        .resp_r1_i   (resp_r1)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  mo_q[$];
    logic [7:0]  rxq[$];
    logic [7:0]  exp_mo[$];
    logic [45:0] capq[$];
    logic [45:0] exp_cap[$];

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (cmd_valid) capq.push_back({cmd_index, cmd_arg, cmd_crc, crc_err});
    end

    // CRC7 as the remainder of d*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic exp_crc_err(input logic [47:0] f);
        return CRC_EN && (crc7_ref(f[47:8]) != f[7:1]);
    endfunction

    task automatic spi_xfer(input logic [7:0] b, input int nbits,
                            output logic [7:0] r);
        r = 8'hFF;
        for (int k = 0; k < nbits; k++) begin
            mosi = b[7-k];
            repeat (8) @(negedge clk);
            r[7-k] = miso;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_select();
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_release();
        cs = 1'b1;
        mosi = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic begin_session();
        @(negedge clk);
        tx_q.delete();
        exp_mo.delete();
        exp_cap.delete();
        capq.delete();
        rxq.delete();
        mo_q.delete();
    endtask

    task automatic add_fill(input logic [7:0] b);
        tx_q.push_back(b);
        exp_mo.push_back(8'hFF);
    endtask

    // Card answers FF during the frame and NCR gap, then R1.
    task automatic add_frame(input logic [47:0] f, input logic [7:0] r1);
        logic e;
        e = exp_crc_err(f);
        for (int i = 5; i >= 0; i--) add_fill(f[i*8+:8]);
        for (int i = 0; i < NCR; i++) add_fill(8'hFF);
        tx_q.push_back(8'hFF);
        exp_mo.push_back(r1 | (e ? 8'h08 : 8'h00));
        exp_cap.push_back({f[45:40], f[39:8], f[7:1], e});
    endtask

    task automatic run_session();
        logic [7:0] r;
        cs_select();
        for (int i = 0; i < tx_q.size(); i++) begin
            spi_xfer(tx_q[i], 8, r);
            mo_q.push_back(r);
        end
        repeat (6) @(negedge clk);
        cs_release();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (miso !== 1'b1) begin
            errors++; $display("FAIL rst_miso: got %b want 1", miso);
        end
        checks++;
        if ({rx_valid, cmd_valid, crc_err} !== 3'b000) begin
            errors++; $display("FAIL rst_strobes: got %b want 000", {rx_valid, cmd_valid, crc_err});
        end
        checks++;
        if ({rx_data, cmd_index, cmd_arg, cmd_crc} !== 53'h0) begin
            errors++; $display("FAIL rst_fields: got %h want 0", {rx_data, cmd_index, cmd_arg, cmd_crc});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (miso !== 1'b1) begin
            errors++; $display("FAIL idle_miso: got %b want 1", miso);
        end
    endtask

    task automatic test_cmd_table();
        logic [47:0] frm[3];
        logic [7:0]  r1s[3];
        frm[0] = 48'h40_00000000_95; r1s[0] = 8'h01;
        frm[1] = 48'h48_000001AA_87; r1s[1] = 8'h01;
        frm[2] = 48'h51_00001200_FF; r1s[2] = 8'h00;
        for (int t = 0; t < 3; t++) begin
            begin_session();
            resp_r1 = r1s[t];
            add_frame(frm[t], r1s[t]);
            add_fill(8'hFF);
            run_session();
            checks++;
            if (capq.size() !== 1) begin
                errors++; $display("FAIL table%0d cmd_count: got %0d want 1", t, capq.size());
            end else begin
                checks++;
                if (capq[0] !== exp_cap[0]) begin
                    errors++; $display("FAIL table%0d fields: got %h want %h", t, capq[0], exp_cap[0]);
                end
            end
            for (int i = 0; i < exp_mo.size(); i++) begin
                checks++;
                if (mo_q[i] !== exp_mo[i]) begin
                    errors++; $display("FAIL table%0d miso[%0d]: got %h want %h", t, i, mo_q[i], exp_mo[i]);
                end
            end
            checks++;
            if (rxq.size() !== tx_q.size()) begin
                errors++; $display("FAIL table%0d rx_count: got %0d want %0d", t, rxq.size(), tx_q.size());
            end
        end
    endtask

    task automatic test_hunt_ff();
        begin_session();
        resp_r1 = 8'h01;
        add_fill(8'hFF);
        add_fill(8'hFF);
        add_frame(48'h40_00000000_95, 8'h01);
        add_fill(8'hFF);
        run_session();
        checks++;
        if (capq.size() !== 1) begin
            errors++; $display("FAIL hunt cmd_count: got %0d want 1", capq.size());
        end
        checks++;
        if (rxq.size() !== tx_q.size()) begin
            errors++; $display("FAIL hunt rx_count: got %0d want %0d", rxq.size(), tx_q.size());
        end else begin
            for (int i = 0; i < tx_q.size(); i++) begin
                checks++;
                if (rxq[i] !== tx_q[i]) begin
                    errors++; $display("FAIL hunt rx[%0d]: got %h want %h", i, rxq[i], tx_q[i]);
                end
            end
        end
        for (int i = 0; i < exp_mo.size(); i++) begin
            checks++;
            if (mo_q[i] !== exp_mo[i]) begin
                errors++; $display("FAIL hunt miso[%0d]: got %h want %h", i, mo_q[i], exp_mo[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        begin_session();
        cs_select();
        spi_xfer(8'h40, 8, r);
        spi_xfer(8'h12, 8, r);
        spi_xfer(8'h34, 8, r);
        repeat (4) @(negedge clk);
        cs_release();
        checks++;
        if (miso !== 1'b1) begin
            errors++; $display("FAIL abort_miso: got %b want 1", miso);
        end
        checks++;
        if (capq.size() !== 0 || rxq.size() !== 3) begin
            errors++; $display("FAIL abort_counts: got cmd=%0d rx=%0d want cmd=0 rx=3", capq.size(), rxq.size());
        end
        begin_session();
        resp_r1 = 8'h01;
        add_frame(48'h40_00000000_95, 8'h01);
        add_fill(8'hFF);
        run_session();
        checks++;
        if (capq.size() !== 1 || capq[0] !== exp_cap[0]) begin
            errors++; $display("FAIL abort_next: got n=%0d %h want n=1 %h", capq.size(), capq.size() > 0 ? capq[0] : 46'h0, exp_cap[0]);
        end
        checks++;
        if (mo_q[6+NCR] !== 8'h01) begin
            errors++; $display("FAIL abort_r1: got %h want 01", mo_q[6+NCR]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  r1, b;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        int          nf, nfill;
        for (int s = 0; s < 5; s++) begin
            begin_session();
            r1 = 8'($urandom);
            resp_r1 = r1;
            nf = $urandom_range(1, 3);
            for (int k = 0; k < nf; k++) begin
                nfill = $urandom_range(0, 2);
                for (int j = 0; j < nfill; j++) begin
                    b = 8'($urandom);
                    if (b[7:6] == 2'b01) b[7] = 1'b1;
                    add_fill(b);
                end
                idx = 6'($urandom);
                arg = $urandom;
                crc = crc7_ref({2'b01, idx, arg});
                if ($urandom_range(0, 1) == 1) crc = 7'($urandom);
                add_frame({2'b01, idx, arg, crc, 1'b1}, r1);
            end
            add_fill(8'hFF);
            run_session();
            checks++;
            if (capq.size() !== exp_cap.size()) begin
                errors++; $display("FAIL rand%0d cmd_count: got %0d want %0d", s, capq.size(), exp_cap.size());
            end
            for (int i = 0; i < exp_cap.size() && i < capq.size(); i++) begin
                checks++;
                if (capq[i] !== exp_cap[i]) begin
                    errors++; $display("FAIL rand%0d cmd%0d: got %h want %h", s, i, capq[i], exp_cap[i]);
                end
            end
            for (int i = 0; i < exp_mo.size(); i++) begin
                checks++;
                if (mo_q[i] !== exp_mo[i]) begin
                    errors++; $display("FAIL rand%0d miso[%0d]: got %h want %h", s, i, mo_q[i], exp_mo[i]);
                end
            end
            checks++;
            if (rxq != tx_q) begin
                errors++; $display("FAIL rand%0d rx_bytes: got n=%0d want n=%0d", s, rxq.size(), tx_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_r1();
        logic [7:0] r;
        begin_session();
        resp_r1 = 8'h01;
        add_frame(48'h40_00000000_95, 8'h01);
        cs_select();
        for (int i = 0; i < 6 + NCR; i++) spi_xfer(tx_q[i], 8, r);
        spi_xfer(tx_q[6+NCR], 4, r);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (miso !== 1'b1 || rx_valid !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_outs: got miso=%b rxv=%b cmdv=%b want 1 0 0", miso, rx_valid, cmd_valid);
        end
        checks++;
        if ({cmd_index, cmd_arg, cmd_crc} !== 45'h0) begin
            errors++; $display("FAIL midrst_fields: got %h want 0", {cmd_index, cmd_arg, cmd_crc});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        capq.delete();
        rxq.delete();
        for (int i = 0; i < 6; i++) spi_xfer(tx_q[i], 8, r);
        repeat (6) @(negedge clk);
        checks++;
        if (capq.size() !== 0 || rxq.size() !== 0 || miso !== 1'b1) begin
            errors++; $display("FAIL midrst_idle: got cmd=%0d rx=%0d miso=%b want 0 0 1", capq.size(), rxq.size(), miso);
        end
        cs_release();
        begin_session();
        add_frame(48'h40_00000000_95, 8'h01);
        add_fill(8'hFF);
        run_session();
        checks++;
        if (capq.size() !== 1 || mo_q[6+NCR] !== 8'h01) begin
            errors++; $display("FAIL midrst_recover: got n=%0d r1=%h want n=1 r1=01", capq.size(), mo_q[6+NCR]);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_table();
        test_hunt_ff();
        test_abort();
        test_back_to_back();
        test_reset_mid_r1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
